// File: rtl/ecd_pkg.sv
// Shared types and TDATA field layout for the ECD row responder.
package ecd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } row_state_e;

  localparam int TDATA_W  = 256;
  localparam int ID_W     = 32;
  localparam int ID_LSB   = 0;
  localparam int BEAT_LSB = 32;
  localparam int BEAT_W   = 8;

  // One row data beat: request ID in the low word, beat index above it, rest zero.
  function automatic logic [TDATA_W-1:0] beat_word(input logic [ID_W-1:0]   id,
                                                   input logic [BEAT_W-1:0] beat);
    logic [TDATA_W-1:0] w;
    w = '0;
    w[ID_LSB +: ID_W]     = id;
    w[BEAT_LSB +: BEAT_W] = beat;
    return w;
  endfunction

endpackage

// File: rtl/ecd_sync_fifo.sv
// Synchronous FIFO with first-word fall-through head, registered count and full flag.
module ecd_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;

endmodule

// File: rtl/ecd_row_responder.sv
// ECD row responder: queues request IDs and answers each with one delayed data row.
// Build option ECD_SEQ_CHECK_EN adds the request-ID sequence checker behind SEQ_ERRORS.
module ecd_row_responder
  import ecd_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int ROW_BEATS    = 32,
  parameter int RESP_LATENCY = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [TDATA_W-1:0] AXIS_RX_TDATA,
  input  logic               AXIS_RX_TVALID,
  input  logic               AXIS_RX_TLAST,
  output logic               AXIS_RX_TREADY,
  output logic [TDATA_W-1:0] AXIS_TX_TDATA,
  output logic               AXIS_TX_TVALID,
  output logic               AXIS_TX_TLAST,
  input  logic               AXIS_TX_TREADY,
  output logic               ROW_COMPLETE,
  output logic [31:0]        ROWS_SERVED,
  output logic [15:0]        SEQ_ERRORS
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int LAT_W = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;
  localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(RESP_LATENCY - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(ROW_BEATS - 1);

  row_state_e         state_q;
  logic [LAT_W-1:0]   lat_q;
  logic [BEAT_W-1:0]  beat_q;
  logic               tvalid_q, tlast_q, row_complete_q;
  logic [TDATA_W-1:0] tdata_q;
  logic [31:0]        rows_served_q;

  logic [ID_W-1:0]    head_id;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full, fifo_empty, rx_push, row_pop, tx_fire;
  logic               unused_rx;

  assign rx_push    = AXIS_RX_TVALID & ~fifo_full;
  assign row_pop    = (state_q == DONE);
  assign fifo_empty = (fifo_count == '0);
  assign tx_fire    = tvalid_q & AXIS_TX_TREADY;
  assign unused_rx  = ^{AXIS_RX_TDATA[TDATA_W-1:ID_W], AXIS_RX_TLAST};

  ecd_sync_fifo #(
    .WIDTH (ID_W),
    .DEPTH (FIFO_DEPTH)
  ) u_id_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (rx_push),
    .push_data (AXIS_RX_TDATA[ID_W-1:0]),
    .pop       (row_pop),
    .head      (head_id),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  // The head stays in the queue for the whole row; it is only popped in DONE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= IDLE;
      lat_q          <= '0;
      beat_q         <= '0;
      tvalid_q       <= 1'b0;
      tlast_q        <= 1'b0;
      tdata_q        <= '0;
      row_complete_q <= 1'b0;
      rows_served_q  <= '0;
    end else begin
      row_complete_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q <= WAIT;
            lat_q   <= LAT_INIT;
          end
        end
        WAIT: begin
          if (lat_q == '0) begin
            state_q  <= STREAM;
            beat_q   <= '0;
            tvalid_q <= 1'b1;
            tlast_q  <= (LAST_BEAT == '0);
            tdata_q  <= beat_word(head_id, '0);
          end else begin
            lat_q <= lat_q - LAT_W'(1);
          end
        end
        STREAM: begin
          if (tx_fire) begin
            if (beat_q == LAST_BEAT) begin
              state_q        <= DONE;
              tvalid_q       <= 1'b0;
              tlast_q        <= 1'b0;
              tdata_q        <= '0;
              row_complete_q <= 1'b1;
            end else begin
              beat_q  <= beat_q + BEAT_W'(1);
              tlast_q <= ((beat_q + BEAT_W'(1)) == LAST_BEAT);
              tdata_q <= beat_word(head_id, beat_q + BEAT_W'(1));
            end
          end
        end
        DONE: begin
          rows_served_q <= rows_served_q + 32'd1;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ECD_SEQ_CHECK_EN
  logic [ID_W-1:0] prev_id_q;
  logic            have_prev_q;
  logic [15:0]     seq_errors_q;

  // Checked once per row as it leaves IDLE; the first row after reset has no predecessor.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      prev_id_q    <= '0;
      have_prev_q  <= 1'b0;
      seq_errors_q <= '0;
    end else if (state_q == IDLE && !fifo_empty) begin
      prev_id_q   <= head_id;
      have_prev_q <= 1'b1;
      if (have_prev_q && (head_id != prev_id_q + ID_W'(1)) && (seq_errors_q != 16'hFFFF))
        seq_errors_q <= seq_errors_q + 16'd1;
    end
  end

  assign SEQ_ERRORS = seq_errors_q;
`else
  assign SEQ_ERRORS = '0;
`endif

  assign AXIS_RX_TREADY = ~fifo_full;
  assign AXIS_TX_TDATA  = tdata_q;
  assign AXIS_TX_TVALID = tvalid_q;
  assign AXIS_TX_TLAST  = tlast_q;
  assign ROW_COMPLETE   = row_complete_q;
  assign ROWS_SERVED    = rows_served_q;

endmodule

// File: doc/ecd_row_responder.md
# ecd_row_responder

Downstream consumer of the ECD data-request AXI-Stream.
- Accepts 256-bit request words and queues the 32-bit request IDs.
- For each queued request, waits a programmable service latency, then streams one row of ROW_BEATS data beats.
- Pulses ROW_COMPLETE for one cycle when a row finishes, closing the requester's flow-control loop.
- Serves as a stand-in for the ECD master in lab and simulation builds.

## Interface
Parameters:
- FIFO_DEPTH, 8: request-ID queue depth; power of 2, ≥2.
- ROW_BEATS, 32: data beats per row; 1..256.
- RESP_LATENCY, 16: service delay in cycles; ≥1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- AXIS_RX_TDATA  in  256  request word; only [31:0] (the request ID) is used.
- AXIS_RX_TVALID  in  1  request valid.
- AXIS_RX_TLAST  in  1  ignored.
- AXIS_RX_TREADY  out  1  high when the queue is not full.
- AXIS_TX_TDATA  out  256  row data beat.
- AXIS_TX_TVALID  out  1  beat valid.
- AXIS_TX_TLAST  out  1  high on beat ROW_BEATS-1.
- AXIS_TX_TREADY  in  1  downstream ready.
- ROW_COMPLETE  out  1  one-cycle pulse per finished row.
- ROWS_SERVED  out  32  completed-row count; wraps at 2^32.
- SEQ_ERRORS  out  16  ID-sequence error count; saturates at 0xFFFF.

## Operation
- RX handshake (TVALID & TREADY) pushes TDATA[31:0] into the queue.
- TREADY = (count != FIFO_DEPTH). It depends on count only, so there is no combinational path from a same-cycle pop; a full queue accepts nothing.

Row FSM states:
- IDLE: on queue non-empty → WAIT; load lat = RESP_LATENCY-1.
- WAIT: if lat == 0 → STREAM with beat = 0; otherwise lat decrements each cycle.
- STREAM: TVALID = 1.
  - TDATA[31:0] = head ID, TDATA[39:32] = beat index, TDATA[255:40] = 0.
  - On handshake, beat increments; a handshake on beat ROW_BEATS-1 → DONE.
- DONE: ROW_COMPLETE = 1; pop the queue; increment ROWS_SERVED; → IDLE.

Data-path rules:
- The queue head is read without popping until DONE.
- A push and a pop in the same cycle leave count unchanged.
- TDATA, TLAST and TVALID stay stable while TVALID & !TREADY.

Reset:
- Reset mid-row abandons the row and flushes the queue.
- Next cycle: TVALID = 0, no ROW_COMPLETE, counters cleared.

## Timing
- Reset values:
  - TREADY 1 (queue empty).
  - TX TVALID / TLAST 0; TX TDATA 0.
  - ROW_COMPLETE 0; ROWS_SERVED 0; SEQ_ERRORS 0; FSM in IDLE.
- Latency: RX handshake at edge E0 with the queue empty and FSM in IDLE → first TVALID high after edge E(RESP_LATENCY+1), i.e. 17 cycles with defaults.
- With TX TREADY held high, a row occupies ROW_BEATS consecutive cycles.
- ROW_COMPLETE is high during the cycle after the last-beat handshake.
- Back-to-back rows: the next WAIT begins 2 cycles after the last-beat handshake (DONE, then IDLE).
- All outputs are registered.

## Configuration
- ECD_SEQ_CHECK_EN defined:
  - On each IDLE→WAIT transition, compare the head ID against the previous row's ID + 1 (32-bit wrap).
  - A mismatch increments SEQ_ERRORS, saturating at 0xFFFF.
  - The first row after reset is never counted as an error.
- ECD_SEQ_CHECK_EN undefined: the check logic is absent and SEQ_ERRORS is tied to 0. The port exists in both builds.

## Structure
- Shared package ecd_pkg holds:
  - the FSM state enum (IDLE, WAIT, STREAM, DONE);
  - TDATA field offsets (ID_LSB = 0, BEAT_LSB = 32, BEAT_W = 8).
- One sub-module, ecd_sync_fifo: parameterised width/depth, synchronous reset, first-word fall-through head, count output.

## Test plan
- Single request with ID 0x0000_C008, TX TREADY = 1 → first TVALID 17 cycles after the handshake. Then 32 beats with TDATA[39:32] = 0..31, TLAST on beat 31. ROW_COMPLETE pulses once; ROWS_SERVED = 1.
- Push 10 requests while TX TREADY = 0 → RX TREADY goes low after the 8th acceptance and the 9th waits. Release TX TREADY → all 10 rows are served in order.
- TX TREADY toggled randomly during a row → no beat lost or duplicated, and TDATA is stable while stalled.
- IDs C008, C009, C00B with ECD_SEQ_CHECK_EN → SEQ_ERRORS = 1. The same sequence without the macro → SEQ_ERRORS = 0.
- resetn low for 1 cycle at beat 10 of a row, with 3 requests queued → TVALID low next cycle, the queue is empty, no ROW_COMPLETE, and a new request is served normally afterward.
